// File: rtl/pwm_timer_nch.sv
// Multi-channel PWM timer. A shadowed sawtooth or up/down counter drives
// per-channel compare outputs with complementary dead-time insertion.
module pwm_timer_nch #(
    parameter int NUM_BITS = 16,
    parameter int N_CH     = 4,
    parameter int DT_BITS  = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cfg_start_i,
    input  logic                     cfg_stop_i,
    input  logic                     cfg_rst_i,
    input  logic                     cfg_update_i,
    input  logic [7:0]               cfg_presc_i,
    input  logic                     cfg_updown_i,
    input  logic                     cfg_oneshot_i,
    input  logic [NUM_BITS-1:0]      cfg_cnt_start_i,
    input  logic [NUM_BITS-1:0]      cfg_cnt_end_i,
    input  logic [N_CH*NUM_BITS-1:0] cfg_comp_i,
    input  logic [N_CH-1:0]          cfg_pol_i,
    input  logic [DT_BITS-1:0]       cfg_dt_i,
    output logic [NUM_BITS-1:0]      counter_o,
    output logic [N_CH-1:0]          pwm_o,
    output logic [N_CH-1:0]          pwm_n_o,
    output logic                     evt_end_o,
    output logic                     active_o
);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [7:0]               sh_presc;
    logic                     sh_updown;
    logic                     sh_oneshot;
    logic [NUM_BITS-1:0]      sh_start;
    logic [NUM_BITS-1:0]      sh_end;
    logic [N_CH*NUM_BITS-1:0] sh_comp;
    logic [N_CH-1:0]          sh_pol;
    logic [DT_BITS-1:0]       sh_dt;

    logic                active_q, active_d;
    logic [NUM_BITS-1:0] cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [7:0]          presc_q, presc_d;
    logic                pend_q, pend_d;
    logic                evt_q, evt_d;
    logic                load_shadow;
    logic                tick;
    logic                period_end;

    logic [N_CH-1:0]               raw_q, raw_d, raw_prev_q;
    logic [N_CH-1:0][DT_BITS-1:0]  dc_q, dc_d, run_len;
    logic [N_CH-1:0]               dt_ok;
    logic [N_CH-1:0]               pwm_q, pwm_d, pwmn_q, pwmn_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_presc   <= '0;
            sh_updown  <= 1'b0;
            sh_oneshot <= 1'b0;
            sh_start   <= '0;
            sh_end     <= '0;
            sh_comp    <= '0;
            sh_pol     <= '0;
            sh_dt      <= '0;
        end else if (load_shadow) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sh_presc   <= cfg_presc_i;
            sh_updown  <= cfg_updown_i;
            sh_oneshot <= cfg_oneshot_i;
            sh_start   <= cfg_cnt_start_i;
            sh_end     <= cfg_cnt_end_i;
            sh_comp    <= cfg_comp_i;
            sh_pol     <= cfg_pol_i;
            sh_dt      <= cfg_dt_i;
        end
    end

    assign tick = active_q && (presc_q == sh_presc);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        active_d    = active_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        presc_d     = presc_q;
        pend_d      = pend_q;
        evt_d       = 1'b0;
        load_shadow = 1'b0;
        period_end  = 1'b0;

        if (cfg_stop_i) begin
            active_d = 1'b0;
            pend_d   = 1'b0;
        end else if (cfg_rst_i) begin
            cnt_d   = sh_start;
            presc_d = '0;
            dir_d   = DIR_UP;
        end else if (cfg_start_i && !active_q) begin
            active_d    = 1'b1;
            cnt_d       = cfg_cnt_start_i;
            presc_d     = '0;
            dir_d       = DIR_UP;
            load_shadow = 1'b1;
        end else if (tick) begin
            presc_d = '0;
            if (!sh_updown) begin
                if (cnt_q == sh_end) begin
                    cnt_d      = sh_start;
                    period_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == sh_end) begin
                    dir_d = DIR_DOWN;
                    cnt_d = sh_end - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == sh_start) begin
                    dir_d      = DIR_UP;
                    cnt_d      = sh_start + 1'b1;
                    period_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // The wrap above used the old shadow; a pending copy lands here.
            if (period_end) begin
                evt_d = 1'b1;
                if (sh_oneshot) active_d = 1'b0;
                if (pend_q) begin
                    load_shadow = 1'b1;
                    pend_d      = 1'b0;
                end
            end
        end else if (active_q) begin
            presc_d = presc_q + 8'd1;
        end

        if (cfg_update_i) begin
            if (!active_q)
                load_shadow = 1'b1;
            else if (!cfg_stop_i)
                pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            presc_q  <= '0;
            pend_q   <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            presc_q  <= presc_d;
            pend_q   <= pend_d;
            evt_q    <= evt_d;
        end
    end

    always_comb begin
        raw_d = '0;
        for (int k = 0; k < N_CH; k++)
            raw_d[k] = (cnt_q < sh_comp[k*NUM_BITS +: NUM_BITS]) ^ sh_pol[k];
    end

    // run_len counts prior active cycles at the current raw level, saturating.
    always_comb begin
        run_len = '0;
        dt_ok   = '0;
        pwm_d   = '0;
        pwmn_d  = '0;
        dc_d    = '0;
        for (int k = 0; k < N_CH; k++) begin
            run_len[k] = (raw_q[k] != raw_prev_q[k]) ? '0 : dc_q[k];
            dt_ok[k]   = (run_len[k] >= sh_dt);
            pwm_d[k]   = active_d & raw_q[k] & dt_ok[k];
            pwmn_d[k]  = active_d & ~raw_q[k] & dt_ok[k];
            if (active_q)
                dc_d[k] = (&run_len[k]) ? run_len[k] : run_len[k] + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            raw_q      <= '0;
            raw_prev_q <= '0;
            // NOTE: these per-channel counters are flops, not a RAM, so they take the reset.
            dc_q       <= '0;
            pwm_q      <= '0;
            pwmn_q     <= '0;
        end else begin
            raw_q      <= raw_d;
            raw_prev_q <= raw_q;
            dc_q       <= dc_d;
            pwm_q      <= pwm_d;
            pwmn_q     <= pwmn_d;
        end
    end

    assign counter_o = cnt_q;
    assign pwm_o     = pwm_q;
    assign pwm_n_o   = pwmn_q;
    assign evt_end_o = evt_q;
    assign active_o  = active_q;

endmodule

// File: tb/tb_pwm_timer_nch.sv
// Randomised and directed bench for pwm_timer_nch against a cycle-level
// reference model; dead time is judged on a window of raw-level history.
module tb_pwm_timer_nch;

    localparam int NUM_BITS = 16;
    localparam int N_CH     = 4;
    localparam int DT_BITS  = 8;
    localparam int HL       = 256;
    localparam int MASK     = (1 << NUM_BITS) - 1;

    logic                     clk_i = 1'b0;
    logic                     rstn_i;
    logic                     cfg_start_i, cfg_stop_i, cfg_rst_i, cfg_update_i;
    logic [7:0]               cfg_presc_i;
    logic                     cfg_updown_i, cfg_oneshot_i;
    logic [NUM_BITS-1:0]      cfg_cnt_start_i, cfg_cnt_end_i;
    logic [N_CH*NUM_BITS-1:0] cfg_comp_i;
    logic [N_CH-1:0]          cfg_pol_i;
    logic [DT_BITS-1:0]       cfg_dt_i;
    logic [NUM_BITS-1:0]      counter_o;
    logic [N_CH-1:0]          pwm_o, pwm_n_o;
    logic                     evt_end_o, active_o;

    pwm_timer_nch #(.NUM_BITS(NUM_BITS), .N_CH(N_CH), .DT_BITS(DT_BITS)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_rst_i(cfg_rst_i), .cfg_update_i(cfg_update_i),
        .cfg_presc_i(cfg_presc_i), .cfg_updown_i(cfg_updown_i),
        .cfg_oneshot_i(cfg_oneshot_i),
        .cfg_cnt_start_i(cfg_cnt_start_i), .cfg_cnt_end_i(cfg_cnt_end_i),
        .cfg_comp_i(cfg_comp_i), .cfg_pol_i(cfg_pol_i), .cfg_dt_i(cfg_dt_i),
        .counter_o(counter_o), .pwm_o(pwm_o), .pwm_n_o(pwm_n_o),
        .evt_end_o(evt_end_o), .active_o(active_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_cnt, m_dir, m_pc, m_act, m_evt, m_pend;
    bit [N_CH-1:0] m_raw, m_pwm, m_pwmn;
    int sh_presc, sh_updown, sh_oneshot, sh_start, sh_end, sh_dt;
    int sh_comp [N_CH];
    bit [N_CH-1:0] sh_pol;
    bit hr [N_CH][HL];
    bit ha [HL];
    int hp;

    int comp [N_CH];
    int exp_ud [20] = '{0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1,0,0,1,1};
    int c0, c1, c2, first_evt, second_evt;
    bit found;

    task automatic model_reset();
        m_cnt = 0; m_dir = 0; m_pc = 0; m_act = 0; m_evt = 0; m_pend = 0;
        m_raw = '0; m_pwm = '0; m_pwmn = '0;
        sh_presc = 0; sh_updown = 0; sh_oneshot = 0; sh_start = 0; sh_end = 0; sh_dt = 0;
        sh_pol = '0;
        for (int k = 0; k < N_CH; k++) begin
            sh_comp[k] = 0;
            for (int j = 0; j < HL; j++) hr[k][j] = 1'b0;
        end
        for (int j = 0; j < HL; j++) ha[j] = 1'b0;
        hp = 0;
    endtask

    // True when raw has sat at level v for the last dt+1 cycles, the
    // earlier dt of which the timer was running.
    function automatic bit held(int k, bit v, int dt);
        for (int j = 0; j <= dt; j++) begin
            int idx = (hp - j + HL) % HL;
            if (hr[k][idx] != v) return 1'b0;
            if (j > 0 && !ha[idx]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        int cnt_n, dir_n, pc_n, act_n, pend_n, evt_n;
        bit load, pe;
        bit [N_CH-1:0] raw_n;
        if (!rstn_i) begin
            model_reset();
            return;
        end
        hp = (hp + 1) % HL;
        ha[hp] = m_act[0];
        for (int k = 0; k < N_CH; k++) begin
            hr[k][hp] = m_raw[k];
            raw_n[k]  = (m_cnt < sh_comp[k]) ^ sh_pol[k];
        end
        cnt_n = m_cnt; dir_n = m_dir; pc_n = m_pc; act_n = m_act; pend_n = m_pend;
        evt_n = 0; load = 0; pe = 0;
        if (cfg_stop_i) begin
            act_n = 0; pend_n = 0;
        end else if (cfg_rst_i) begin
            cnt_n = sh_start; pc_n = 0; dir_n = 0;
        end else if (cfg_start_i && m_act == 0) begin
            act_n = 1; cnt_n = int'(cfg_cnt_start_i); pc_n = 0; dir_n = 0; load = 1;
        end else if (m_act != 0) begin
            if (m_pc == sh_presc) begin
                pc_n = 0;
                if (sh_updown == 0) begin
                    if (m_cnt == sh_end) begin cnt_n = sh_start; pe = 1; end
                    else cnt_n = (m_cnt + 1) & MASK;
                end else if (m_dir == 0) begin
                    if (m_cnt == sh_end) begin dir_n = 1; cnt_n = (sh_end - 1) & MASK; end
                    else cnt_n = (m_cnt + 1) & MASK;
                end else begin
                    if (m_cnt == sh_start) begin dir_n = 0; cnt_n = (sh_start + 1) & MASK; pe = 1; end
                    else cnt_n = (m_cnt - 1) & MASK;
                end
                if (pe) begin
                    evt_n = 1;
                    if (sh_oneshot != 0) act_n = 0;
                    if (m_pend != 0) begin load = 1; pend_n = 0; end
                end
            end else begin
                pc_n = m_pc + 1;
            end
        end
        if (cfg_update_i) begin
            if (m_act == 0) load = 1;
            else if (!cfg_stop_i) pend_n = 1;
        end
        for (int k = 0; k < N_CH; k++) begin
            m_pwm[k]  = (act_n != 0) && held(k, 1'b1, sh_dt);
            m_pwmn[k] = (act_n != 0) && held(k, 1'b0, sh_dt);
        end
        m_raw = raw_n;
        m_cnt = cnt_n; m_dir = dir_n; m_pc = pc_n; m_act = act_n; m_pend = pend_n; m_evt = evt_n;
        if (load) begin
            sh_presc   = int'(cfg_presc_i);
            sh_updown  = int'(cfg_updown_i);
            sh_oneshot = int'(cfg_oneshot_i);
            sh_start   = int'(cfg_cnt_start_i);
            sh_end     = int'(cfg_cnt_end_i);
            sh_dt      = int'(cfg_dt_i);
            sh_pol     = cfg_pol_i;
            for (int k = 0; k < N_CH; k++) sh_comp[k] = int'(cfg_comp_i[k*NUM_BITS +: NUM_BITS]);
        end
    endtask

    task automatic compare_all();
        check("counter", counter_o, m_cnt);
        check("active", active_o, m_act);
        check("evt_end", evt_end_o, m_evt);
        check("pwm", pwm_o, m_pwm);
        check("pwm_n", pwm_n_o, m_pwmn);
        check("overlap", pwm_o & pwm_n_o, 0);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive_comp();
        for (int k = 0; k < N_CH; k++) cfg_comp_i[k*NUM_BITS +: NUM_BITS] = NUM_BITS'(comp[k]);
    endtask

    task automatic set_cfg(input int st, input int en, input int ps, input int ud, input int os, input int dt);
        cfg_cnt_start_i = NUM_BITS'(st);
        cfg_cnt_end_i   = NUM_BITS'(en);
        cfg_presc_i     = 8'(ps);
        cfg_updown_i    = ud[0];
        cfg_oneshot_i   = os[0];
        cfg_dt_i        = DT_BITS'(dt);
    endtask

    task automatic pulse(input bit s, input bit p, input bit r, input bit u);
        cfg_start_i = s; cfg_stop_i = p; cfg_rst_i = r; cfg_update_i = u;
        step();
        cfg_start_i = 0; cfg_stop_i = 0; cfg_rst_i = 0; cfg_update_i = 0;
    endtask

    task automatic randomize_cfg();
        set_cfg($urandom_range(0, 3), $urandom_range(5, 10), $urandom_range(0, 2),
                $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 4));
        for (int k = 0; k < N_CH; k++) comp[k] = $urandom_range(0, 11);
        drive_comp();
        cfg_pol_i = N_CH'($urandom);
    endtask

    initial begin
        rstn_i = 0;
        cfg_start_i = 0; cfg_stop_i = 0; cfg_rst_i = 0; cfg_update_i = 0;
        set_cfg(0, 4, 0, 0, 0, 0);
        cfg_pol_i = '0;
        for (int k = 0; k < N_CH; k++) comp[k] = 0;
        drive_comp();
        model_reset();
        repeat (2) step();
        rstn_i = 1;
        step();

        // Sawtooth 0..4, comp0=2
        comp[0] = 2; comp[1] = 1; comp[2] = 4; comp[3] = 5;
        drive_comp();
        pulse(1, 0, 0, 0);
        check("saw_first", counter_o, 0);
        c0 = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("saw_seq", counter_o, i % 5);
            if (evt_end_o) c0++;
        end
        check("saw_evt_count", c0, 2);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            c0 += int'(pwm_o[0]);
            c1 += int'(pwm_n_o[0]);
        end
        check("saw_pwm_high", c0, 4);
        check("saw_pwmn_high", c1, 6);

        // Up/down 0..4, presc=1
        pulse(0, 1, 0, 0);
        set_cfg(0, 4, 1, 1, 0, 0);
        pulse(1, 0, 0, 0);
        check("ud_seq", counter_o, exp_ud[0]);
        first_evt = -1; second_evt = -1;
        for (int i = 1; i < 40; i++) begin
            step();
            if (i < 20) check("ud_seq", counter_o, exp_ud[i]);
            if (evt_end_o) begin
                if (first_evt < 0) first_evt = i;
                else if (second_evt < 0) second_evt = i;
            end
        end
        check("ud_first_evt", first_evt, 18);
        check("ud_evt_period", second_evt - first_evt, 16);

        // Dead time 3 with a 10-cycle raw high and a 2-cycle raw pulse
        pulse(0, 1, 0, 0);
        set_cfg(0, 19, 0, 0, 0, 3);
        comp[0] = 10; comp[1] = 2;
        drive_comp();
        pulse(1, 0, 0, 0);
        repeat (25) step();
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            c0 += int'(pwm_o[0]);
            c1 += int'(pwm_n_o[0]);
            c2 += int'(pwm_o[1]);
        end
        check("dt_pwm_high", c0, 14);
        check("dt_pwmn_high", c1, 14);
        check("dt_short_pulse", c2, 0);

        // Shadow update mid-period: comp0 2 -> 3
        pulse(0, 1, 0, 0);
        set_cfg(0, 4, 0, 0, 0, 0);
        comp[0] = 2;
        drive_comp();
        pulse(1, 0, 0, 0);
        repeat (7) step();
        comp[0] = 3;
        drive_comp();
        pulse(0, 0, 0, 1);
        repeat (12) step();
        c0 = 0;
        for (int i = 0; i < 5; i++) begin step(); c0 += int'(pwm_o[0]); end
        check("upd_new_duty", c0, 3);
        comp[0] = 1;
        drive_comp();
        repeat (10) step();
        c0 = 0;
        for (int i = 0; i < 5; i++) begin step(); c0 += int'(pwm_o[0]); end
        check("upd_pending_cleared", c0, 3);

        // Oneshot, end=3
        pulse(0, 1, 0, 0);
        set_cfg(0, 3, 0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (evt_end_o) found = 1;
        end
        check("oneshot_evt_seen", found, 1);
        check("oneshot_inactive", active_o, 0);
        check("oneshot_counter", counter_o, 0);
        step();
        check("oneshot_pwm", pwm_o, 0);
        check("oneshot_pwmn", pwm_n_o, 0);

        // Commands and asynchronous reset
        set_cfg(2, 6, 0, 0, 0, 0);
        pulse(1, 1, 0, 0);
        check("start_stop_active", active_o, 0);
        pulse(1, 0, 0, 0);
        repeat (3) step();
        pulse(0, 0, 1, 0);
        check("rst_counter", counter_o, 2);
        check("rst_active", active_o, 1);
        repeat (4) step();
        #2;
        rstn_i = 0;
        #1;
        model_reset();
        check("arst_counter", counter_o, 0);
        check("arst_active", active_o, 0);
        check("arst_pwm", pwm_o, 0);
        check("arst_pwmn", pwm_n_o, 0);
        check("arst_evt", evt_end_o, 0);
        repeat (2) step();
        rstn_i = 1;

        // Randomised run
        randomize_cfg();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) randomize_cfg();
            cfg_start_i  = ($urandom_range(0, 19) == 0);
            cfg_stop_i   = ($urandom_range(0, 79) == 0);
            cfg_rst_i    = ($urandom_range(0, 79) == 0);
            cfg_update_i = ($urandom_range(0, 24) == 0);
            if (n == 1500) rstn_i = 0;
            if (n == 1503) rstn_i = 1;
            step();
            cfg_start_i = 0; cfg_stop_i = 0; cfg_rst_i = 0; cfg_update_i = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_timer_nch.md
# pwm_timer_nch

Parametrised multi-channel PWM timer for the APB advanced-timer subsystem. It replaces the fixed 4-channel, fixed 16-bit timer with configurable counter width and channel count. It adds up/down (centre-aligned) counting, shadowed configuration with glitch-free period-boundary update, one-shot mode, and complementary outputs with dead-time insertion. It is driven by the APB register block through level configs and single-cycle command pulses.

## Interface
- NUM_BITS, 16, counter and compare width (2..32)
- N_CH, 4, number of PWM channels (1..8)
- DT_BITS, 8, dead-time counter width
- clk_i  in  1  system clock; all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_start_i / cfg_stop_i / cfg_rst_i / cfg_update_i  in  1 each  single-cycle command pulses
- cfg_presc_i  in  8  prescaler; tick every cfg_presc_i+1 cycles
- cfg_updown_i  in  1  0 = sawtooth, 1 = up/down
- cfg_oneshot_i  in  1  stop after first period end
- cfg_cnt_start_i / cfg_cnt_end_i  in  NUM_BITS each  count range, start < end required
- cfg_comp_i  in  N_CH*NUM_BITS  compare value, channel k at [k*NUM_BITS +: NUM_BITS]
- cfg_pol_i  in  N_CH  per-channel output inversion
- cfg_dt_i  in  DT_BITS  dead time in clk cycles
- counter_o  out  NUM_BITS  active count
- pwm_o / pwm_n_o  out  N_CH each  main / complementary outputs
- evt_end_o  out  1  one-cycle pulse at period end
- active_o  out  1  timer running

## Operation
- Shadow set: presc, updown, oneshot, cnt_start, cnt_end, comp, pol, dt.
  - cfg_update_i while idle copies cfg_* into shadow next cycle.
  - cfg_update_i while active sets a pending flag. The copy happens on the cycle of the next period end. The flag then clears.
  - cfg_start_i from idle also copies all cfg_*.
- Commands:
  - start (idle only): active=1, counter=cnt_start, prescaler=0, dir=up.
  - start while active: ignored.
  - stop: active=0, counter holds its value, pending flag clears.
  - rst: counter=cnt_start, prescaler=0, dir=up, active unchanged.
  - Priority when pulsed together: stop > rst > start. update combines with any of them.
- Prescaler: counts 0..presc while active and emits a tick on wrap. presc=0 means a tick every cycle.
- Sawtooth mode, on each tick:
  - cnt==end: cnt becomes start and period end fires.
  - otherwise cnt+1.
- Up/down mode, on each tick:
  - Up: cnt+1. At end, dir becomes down and cnt becomes end-1.
  - Down: cnt-1. At start, dir becomes up, cnt becomes start+1, and period end fires.
  - The period is 2*(end-start) ticks.
- Oneshot: at the first period end, active becomes 0 and the counter holds the post-wrap value (start, or start+1 in up/down mode).
- Compare: raw_k = (cnt < comp_k) XOR pol_k, using the shadow comp. comp_k ≤ start gives raw=pol; comp_k > end gives raw=~pol.
- Dead time, per channel:
  - A counter restarts on each raw_k edge.
  - pwm_o[k] rises only once raw_k has been 1 for dt cycles. pwm_n_o[k] rises only once raw_k has been 0 for dt cycles.
  - Both outputs fall immediately. pwm_o and pwm_n_o are never 1 together.
  - dt=0: pwm_n_o = ~pwm_o.
  - A raw pulse shorter than dt is suppressed on that output.
- Idle (active=0): pwm_o=0, pwm_n_o=0, dead-time counters cleared.

## Timing
- Reset values: counter_o=0, pwm_o=0, pwm_n_o=0, evt_end_o=0, active_o=0, all shadows=0, pending=0, dir=up.
- Start pulse at cycle T:
  - active_o=1 and counter_o=start at T+1.
  - First tick at T+1+presc. The count moves at T+2+presc.
- evt_end_o is registered and high for exactly the cycle in which counter_o first shows the wrapped value.
- raw_k is registered: it follows counter_o by 1 cycle.
- Outputs lag raw:
  - dt=0: pwm_o/pwm_n_o follow raw by 1 cycle.
  - Rising output: dt+1 cycles after the raw edge.
  - Falling output: 1 cycle after the raw edge.
- A shadow update at period end takes effect on the first count after the wrap. The wrap itself uses the old end.
- Asynchronous reset mid-run returns every register to its reset value immediately.

## Test plan
- Sawtooth: start=0, end=4, presc=0, comp0=2, dt=0.
  - counter_o cycles 0,1,2,3,4,0.
  - evt_end_o pulses every 5 cycles.
  - pwm_o[0] is high 2 of every 5 cycles; pwm_n_o[0] is its inverse.
- Up/down: start=0, end=4, presc=1.
  - counter_o runs 0,1,2,3,4,3,2,1,0,1, advancing every 2 cycles.
  - evt_end_o fires at each return to 0, with a period of 16 cycles.
- Dead time: dt=3 with a 10-cycle-high raw waveform.
  - pwm_o is high for 7 cycles; pwm_n_o rises 4 cycles after the raw fall.
  - pwm_o and pwm_n_o are never both 1.
  - A 2-cycle raw pulse produces no pwm_o pulse.
- Shadow update: comp0 changes from 2 to 3 with cfg_update_i mid-period.
  - The old duty cycle holds until the period end; the new duty applies from the next period.
  - The pending flag clears after the update.
- Oneshot: set cfg_oneshot_i=1 with end=3.
  - After one evt_end_o pulse, active_o=0, counter_o=0, and pwm_o=pwm_n_o=0.
- Commands and reset: pulse start and stop in the same cycle, then rst while active, then deassert rstn_i mid-run.
  - start+stop: active_o stays 0.
  - rst: counter returns to start the next cycle and active_o stays 1.
  - rstn_i low: all outputs are 0 immediately.
